// File: rtl/cv32e40p_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Uses the EX-stage multicycle handshake; divide-by-zero and overflow can resolve in the issue cycle.
module cv32e40p_div #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        multicycle_o,
  output logic        ready_o,
  input  logic        ex_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] dividend_reg, divisor_reg, quot_reg, rem_reg;
  logic [4:0]  cnt_reg;
  logic        rem_sel_reg, neg_q_reg, neg_r_reg;

  logic        is_signed, b_zero, ovf, special, start;
  logic [31:0] a_mag, b_mag, special_result;
  logic [32:0] r_shift;
  logic        q_bit;
  logic [31:0] r_sub, q_final, r_final;

  // Issue-cycle decode from the live inputs
  assign is_signed = ~operator_i[0];
  assign a_mag     = (is_signed && op_a_i[31]) ? -op_a_i : op_a_i;
  assign b_mag     = (is_signed && op_b_i[31]) ? -op_b_i : op_b_i;
  assign b_zero    = (op_b_i == 32'h0);
  assign ovf       = is_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
  assign special   = EARLY_OUT && (b_zero || ovf);

  always_comb begin
    special_result = 32'h0;
    if (operator_i[1])
      special_result = b_zero ? op_a_i : 32'h0;
    else
      special_result = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

  // The stored remainder is always below the divisor, so 32 bits hold it;
  // only the shifted trial value needs the extra bit.
  assign r_shift = {rem_reg, dividend_reg[31]};
  assign q_bit   = (r_shift >= {1'b0, divisor_reg});
  assign r_sub   = r_shift[31:0] - divisor_reg;

  assign q_final = neg_q_reg ? -quot_reg : quot_reg;
  assign r_final = neg_r_reg ? -rem_reg  : rem_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    ready_o      = 1'b1;
    multicycle_o = 1'b0;
    result_o     = 32'h0;
    start        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_i) begin
          if (special) begin
            result_o = special_result;
          end else begin
            start      = 1'b1;
            ready_o    = 1'b0;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        ready_o      = 1'b0;
        multicycle_o = 1'b1;
        if (cnt_reg == 5'd0) state_next = FINISH;
      end
      FINISH: begin
        result_o = rem_sel_reg ? r_final : q_final;
        if (ex_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero divisor keeps the quotient unsigned so the iterated result is all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_reg <= 32'h0;
      divisor_reg  <= 32'h0;
      quot_reg     <= 32'h0;
      rem_reg      <= 32'h0;
      cnt_reg      <= 5'd0;
      rem_sel_reg  <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
    end else if (start) begin
      dividend_reg <= a_mag;
      divisor_reg  <= b_mag;
      quot_reg     <= 32'h0;
      rem_reg      <= 32'h0;
      cnt_reg      <= 5'd31;
      rem_sel_reg  <= operator_i[1];
      neg_q_reg    <= is_signed && (op_a_i[31] ^ op_b_i[31]) && !b_zero;
      neg_r_reg    <= is_signed && op_a_i[31];
    end else if (state_reg == BUSY) begin
      dividend_reg <= {dividend_reg[30:0], 1'b0};
      quot_reg     <= {quot_reg[30:0], q_bit};
      rem_reg      <= q_bit ? r_sub : r_shift[31:0];
      cnt_reg      <= cnt_reg - 5'd1;
    end
  end

endmodule
